mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle control unit that sequences the shared MIPS datapath: one ALU, one unified instruction/data memory, and the register file. Each instruction is broken into FETCH, DECODE and execute/writeback steps.
- Decodes op/funct and drives every datapath mux select and write enable.
- Stalls on a memory-ready handshake.
- Keeps a retired-instruction counter.
- Sits beside the datapath inside the top-level MIPS core, replacing the single-cycle combinational decoder.

Parameters:
CNT_W, 16, width of retired-instruction counter
ALU_W, 3, width of ALU control code

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
pc_en  out  1  PC register load
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = Data
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
alu_control  out  ALU_W  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
illegal  out  1  one-cycle pulse on unsupported op/funct
state_dbg  out  4  current state encoding
retired  out  CNT_W  completed-instruction count

Behaviour:
- Reset (async): state = FETCH; retired = 0; write strobes (pc_en, ir_write, mem_write, reg_write) forced 0 while reset is high; illegal = 0.
- Moore outputs decoded from state. pc_en = pc_write | (branch & zero).
- Unlisted outputs are 0. Each state and its outputs:
  - FETCH(0): alu_src_b = 01, ALU ADD. ir_write = pc_write = mem_ready. Stays in FETCH until mem_ready = 1, then goes to DECODE.
  - DECODE(1): alu_src_b = 11, ADD (branch target into ALUOut). Next state by op:
    - 0x23/0x2B -> MEMADR
    - 0x00 -> EXECUTE
    - 0x04 -> BRANCH
    - 0x08 -> ADDIEX
    - 0x02 -> JUMP
    - any other op -> FETCH, illegal = 1 for that cycle, retired not incremented.
  - MEMADR(2): alu_src_a = 1, alu_src_b = 10, ADD. Goes to MEMRD for op 0x23, MEMWR for op 0x2B.
  - MEMRD(3): iord = 1. Holds until mem_ready, then MEMWB.
  - MEMWB(4): mem_to_reg = 1, reg_write = 1. Then FETCH.
  - MEMWR(5): iord = 1, mem_write = mem_ready. Holds until mem_ready, then FETCH.
  - EXECUTE(6): alu_src_a = 1, alu_src_b = 00, alu_control from funct:
    - 0x20 -> 010
    - 0x22 -> 110
    - 0x24 -> 000
    - 0x25 -> 001
    - 0x2A -> 111
    - any other funct -> 010 and illegal pulse; ALUWB still proceeds.
    - Next state ALUWB.
  - ALUWB(7): reg_dst = 1, reg_write = 1. Then FETCH.
  - BRANCH(8): alu_src_a = 1, SUB, pc_src = 01, branch = 1. Then FETCH.
  - ADDIEX(9): alu_src_a = 1, alu_src_b = 10, ADD. Then ADDIWB.
  - ADDIWB(10): reg_write = 1. Then FETCH.
  - JUMP(11): pc_src = 10, pc_write = 1. Then FETCH.
- Encodings 12–15 are unreachable; if entered, go to FETCH.
- retired increments on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^CNT_W.
- Latency in cycles with mem_ready held high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory stall cycle adds 1.
- Reset asserted mid-instruction: immediate return to FETCH; the partial instruction is not counted; no write strobe is asserted during reset.
- mem_ready is ignored in states that do not access memory.

Decomposition:
- Package mips_ctrl_pkg:
  - state_t enum
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU code constants
  - alu_op_t (00 add, 01 sub, 10 funct)
- One sub-module: mips_alu_decoder (combinational; alu_op + funct -> alu_control, illegal_funct).
- The FSM and the counter stay in mips_multicycle_ctrl.

Test Plan:
- Reset during MEMRD of lw (instr 0x8C080004) -> state_dbg = 0 immediately, retired = 0, no reg_write.
- lw 0x8C080004, mem_ready = 1 -> states 0,1,2,3,4,0; reg_write only in state 4, mem_to_reg = 1; retired = 1.
- sw 0xAC080008, mem_ready low for 2 cycles in MEMWR -> mem_write pulses exactly once, on the ready cycle; 6 cycles total.
- add 0x01095020 then slt (funct 0x2A) -> alu_control = 010 then 111 in EXECUTE; reg_dst = 1 in ALUWB.
- beq with zero = 1 vs zero = 0 -> pc_en = 1 vs 0 in BRANCH, pc_src = 01; j 0x08000010 -> pc_src = 10, pc_en = 1.
- op 0x3F -> illegal pulses 1 cycle in DECODE, returns to FETCH, retired unchanged; 65536 retired instrs with CNT_W = 16 -> counter wraps to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control: alu_op selects add/sub directly or defers to funct.
// Unknown funct falls back to ADD and raises illegal_funct_o.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       illegal_funct_o
);

  always_comb begin
    alu_ctrl_o      = ALU_ADD;
    illegal_funct_o = 1'b0;
    case (alu_op_i)
      ALUOP_SUB:   alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: illegal_funct_o = 1'b1;
        endcase
      end
      default:     alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute, stalls on mem_ready,
// counts retired instructions. Write strobes are held low while reset is high.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ALU_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  alu_op_t    alu_op;
  logic       alu_en, pc_write, branch, illegal_op, retire;
  logic       ir_write_c, mem_write_c, reg_write_c;
  logic [2:0] alu_code;
  logic       illegal_funct;

  mips_alu_decoder u_alu_dec (
    .alu_op_i        (alu_op),
    .funct_i         (funct),
    .alu_ctrl_o      (alu_code),
    .illegal_funct_o (illegal_funct)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    alu_op      = ALUOP_ADD;
    alu_en      = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    illegal_op  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        alu_en     = 1'b1;
        ir_write_c = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_en    = 1'b1;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_en    = 1'b1;
        state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_c = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        alu_en    = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        alu_en    = 1'b1;
        pc_src    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_en    = 1'b1;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Only completed instructions count; illegal-op aborts and stray states do not.
  assign retire    = (state_d == S_FETCH) &&
                     (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP});
  assign retired_d = retire ? retired_q + 1'b1 : retired_q;

  assign pc_en       = ~reset & (pc_write | (branch & zero));
  assign ir_write    = ~reset & ir_write_c;
  assign mem_write   = ~reset & mem_write_c;
  assign reg_write   = ~reset & reg_write_c;
  assign illegal     = ~reset & (illegal_op | ((state_q == S_EXECUTE) & illegal_funct));
  assign alu_control = alu_en ? ALU_W'(alu_code) : '0;
  assign state_dbg   = state_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized + directed bench: each instruction is expanded into its list of steps
// and every cycle's outputs are compared with a per-step expectation table.
module tb_mips_multicycle_ctrl;

  localparam int CW = 8;  // narrow counter so the wrap case stays short

  logic          clk, rst;
  logic [5:0]    op_s, funct_s;
  logic          zero_s, mr_s;
  logic          pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, pc_src;
  logic [2:0]    alu_control;
  logic          illegal;
  logic [3:0]    state_dbg;
  logic [CW-1:0] retired;

  mips_multicycle_ctrl #(.CNT_W(CW), .ALU_W(3)) dut (
    .clk(clk), .reset(rst), .op(op_s), .funct(funct_s), .zero(zero_s), .mem_ready(mr_s),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .illegal(illegal), .state_dbg(state_dbg), .retired(retired)
  );

  typedef struct packed {
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  outs_t got;
  assign got = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, pc_src, alu_control, illegal, state_dbg};

  // Instruction steps; the numeric value is the state number the step must report.
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MW = 4, P_WR = 5;
  localparam int P_EX = 6, P_AW = 7, P_BR = 8, P_AE = 9, P_AWB = 10, P_JP = 11;

  int checks = 0, errors = 0;
  int model_retired = 0;
  int plan[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  function automatic bit legal_op(input logic [5:0] o);
    return o == 6'h23 || o == 6'h2B || o == 6'h00 || o == 6'h04 || o == 6'h08 || o == 6'h02;
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    case (f)
      6'h20:   return {1'b0, 3'b010};
      6'h22:   return {1'b0, 3'b110};
      6'h24:   return {1'b0, 3'b000};
      6'h25:   return {1'b0, 3'b001};
      6'h2A:   return {1'b0, 3'b111};
      default: return {1'b1, 3'b010};
    endcase
  endfunction

  function automatic bit is_mem(input int ph);
    return ph == P_F || ph == P_MR || ph == P_WR;
  endfunction

  function automatic outs_t expect_outs(input int ph, input logic [5:0] o, input logic [5:0] f,
                                        input logic z, input logic mr);
    outs_t e;
    logic [3:0] fa;
    e = '0;
    e.state = 4'(ph);
    fa = funct_alu(f);
    case (ph)
      P_F:   begin e.alu_src_b = 2'b01; e.alu_control = 3'b010; e.ir_write = mr; e.pc_en = mr; end
      P_D:   begin e.alu_src_b = 2'b11; e.alu_control = 3'b010; e.illegal = !legal_op(o); end
      P_MA:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
      P_MR:  e.iord = 1;
      P_MW:  begin e.mem_to_reg = 1; e.reg_write = 1; end
      P_WR:  begin e.iord = 1; e.mem_write = mr; end
      P_EX:  begin e.alu_src_a = 1; e.alu_control = fa[2:0]; e.illegal = fa[3]; end
      P_AW:  begin e.reg_dst = 1; e.reg_write = 1; end
      P_BR:  begin e.alu_src_a = 1; e.alu_control = 3'b110; e.pc_src = 2'b01; e.pc_en = z; end
      P_AE:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
      P_AWB: e.reg_write = 1;
      P_JP:  begin e.pc_src = 2'b10; e.pc_en = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic build_plan(input logic [5:0] o);
    plan = {};
    plan.push_back(P_F);
    plan.push_back(P_D);
    case (o)
      6'h23:   begin plan.push_back(P_MA); plan.push_back(P_MR); plan.push_back(P_MW); end
      6'h2B:   begin plan.push_back(P_MA); plan.push_back(P_WR); end
      6'h00:   begin plan.push_back(P_EX); plan.push_back(P_AW); end
      6'h04:   plan.push_back(P_BR);
      6'h08:   begin plan.push_back(P_AE); plan.push_back(P_AWB); end
      6'h02:   plan.push_back(P_JP);
      default: ;
    endcase
  endtask

  // Stall counts: >=0 gives exactly that many not-ready cycles, <0 randomizes them.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fetch_st, input int data_st);
    int mw_cnt = 0, rw_cnt = 0, exp_rw = 0;
    outs_t e;
    build_plan(o);
    for (int i = 0; i < plan.size(); i++) begin
      int  ph    = plan[i];
      int  limit = (ph == P_F) ? fetch_st : data_st;
      int  k     = 0;
      bit  done  = 0;
      logic mr;
      if (ph == P_MW || ph == P_AW || ph == P_AWB) exp_rw++;
      while (!done) begin
        @(negedge clk);
        if (!is_mem(ph))      mr = 1'($urandom_range(0, 1));
        else if (limit >= 0)  mr = (k >= limit);
        else                  mr = (k >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        op_s = o; funct_s = f; zero_s = z; mr_s = mr;
        #1;
        e = expect_outs(ph, o, f, z, mr);
        check($sformatf("outs step%0d op%02h", ph, o), 32'(got), 32'(e));
        mw_cnt += int'(mem_write);
        rw_cnt += int'(reg_write);
        k++;
        if (!is_mem(ph) || mr) done = 1;
      end
    end
    if (legal_op(o)) model_retired = (model_retired + 1) % (1 << CW);
    @(negedge clk);
    mr_s = 1'b0;
    #1;
    check("back_in_fetch", 32'(state_dbg), 32'd0);
    check("retired", 32'(retired), 32'(model_retired));
    check("mem_write_pulses", 32'(mw_cnt), (o == 6'h2B) ? 32'd1 : 32'd0);
    check("reg_write_pulses", 32'(rw_cnt), 32'(exp_rw));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mr_s = 1'b1;
    #1;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_strobes", {28'd0, pc_en, ir_write, mem_write, reg_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mr_s = 1'b0;
    model_retired = 0;
    #1;
    check("rst_retired", 32'(retired), 32'd0);
  endtask

  initial begin
    logic [5:0] o, f;
    rst = 1'b1; op_s = 6'h23; funct_s = 6'h04; zero_s = 1'b0; mr_s = 1'b1;
    #2;
    check("init_state", 32'(state_dbg), 32'd0);
    check("init_retired", 32'(retired), 32'd0);
    check("init_strobes", {28'd0, pc_en, ir_write, mem_write, reg_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mr_s = 1'b0;

    // lw 0x8C080004 interrupted by reset while stalled in the read step
    @(negedge clk); op_s = 6'h23; mr_s = 1'b1;
    @(negedge clk); mr_s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("lw_in_memrd", 32'(state_dbg), 32'd3);
    rst = 1'b1; mr_s = 1'b1;
    #1;
    check("midrst_state", 32'(state_dbg), 32'd0);
    check("midrst_strobes", {28'd0, pc_en, ir_write, mem_write, reg_write}, 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0; mr_s = 1'b0;

    run_instr(6'h23, 6'h04, 1'b0, 0, 0);   // lw, no stalls
    run_instr(6'h2B, 6'h08, 1'b0, 0, 2);   // sw, two-cycle data stall
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add
    run_instr(6'h00, 6'h2A, 1'b0, 0, 0);   // slt
    run_instr(6'h00, 6'h22, 1'b1, 1, 0);   // sub
    run_instr(6'h00, 6'h24, 1'b0, 0, 0);   // and
    run_instr(6'h00, 6'h25, 1'b0, 0, 0);   // or
    run_instr(6'h00, 6'h3F, 1'b0, 0, 0);   // unknown funct still writes back
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(6'h02, 6'h10, 1'b0, 0, 0);   // j 0x08000010
    run_instr(6'h08, 6'h00, 1'b0, 2, 0);   // addi with fetch stall
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // illegal op

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: o = 6'h23;
        1: o = 6'h2B;
        2: o = 6'h00;
        3: o = 6'h04;
        4: o = 6'h08;
        5: o = 6'h02;
        default: begin
          o = 6'($urandom_range(0, 63));
          if (legal_op(o)) o = 6'h3F;
        end
      endcase
      case ($urandom_range(0, 5))
        0: f = 6'h20;
        1: f = 6'h22;
        2: f = 6'h24;
        3: f = 6'h25;
        4: f = 6'h2A;
        default: f = 6'($urandom_range(0, 63));
      endcase
      run_instr(o, f, 1'($urandom_range(0, 1)), -1, -1);
    end

    // Counter wrap: exactly 2^CW retirements from reset must read back as zero.
    do_reset();
    for (int n = 0; n < (1 << CW); n++) run_instr(6'h02, 6'h00, 1'b0, 0, 0);
    check("wrap_zero", 32'(retired), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
